// File: rtl/fast_pkg.sv
// Shared widths, entry field layout and FSM encoding for the FAST corner FIFO.
package fast_pkg;

  localparam int COORD_W = 10;
  localparam int SCORE_W = 13;
  localparam int ENTRY_W = 34;

  localparam int EOF_BIT = 33;
  localparam int X_LSB   = 23;
  localparam int Y_LSB   = 13;
  localparam int S_LSB   = 0;

  typedef enum logic {
    S_RUN = 1'b0,
    S_EOF = 1'b1
  } fsm_state_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic               eof,
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input logic [SCORE_W-1:0] s
  );
    return {eof, x, y, s};
  endfunction

endpackage

// File: rtl/fast_sync_fifo.sv
// Synchronous FIFO with show-ahead output; pointers carry one wrap bit so full/empty
// are told apart by the MSB compare.
module fast_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             rd_fire;
  logic             wr_fire;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_fire = rd_en && !empty;
  // A write into a full FIFO is legal when the same cycle frees the head slot.
  assign wr_fire = wr_en && (!full || rd_fire);
  assign count   = wr_ptr - rd_ptr;
  assign free    = PW'(DEPTH) - count;
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fast_corner_fifo.sv
// Buffers detected FAST corners and appends one end-of-frame marker per frame.
// Define FAST_CORNER_DROP_CNT_EN to add the saturating drop_cnt output.
module fast_corner_fifo
  import fast_pkg::*;
#(
  parameter int COL_NUM     = 640,
  parameter int ROW_NUM     = 480,
  parameter int FIFO_DEPTH  = 64,
  parameter int MAX_CORNERS = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               iscorner,
  input  logic [COORD_W-1:0] x_coord,
  input  logic [COORD_W-1:0] y_coord,
  input  logic [SCORE_W-1:0] score,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_eof,
  output logic [COORD_W-1:0] m_x,
  output logic [COORD_W-1:0] m_y,
  output logic [SCORE_W-1:0] m_score,
  output logic               overflow
`ifdef FAST_CORNER_DROP_CNT_EN
  ,
  output logic [15:0]        drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 2;
  localparam logic [COORD_W-1:0] LAST_X     = COORD_W'(COL_NUM - 1);
  localparam logic [COORD_W-1:0] LAST_Y     = COORD_W'(ROW_NUM - 1);
  localparam logic [SCORE_W-1:0] CORNER_CAP = SCORE_W'(MAX_CORNERS);

  fsm_state_t         state_q;
  fsm_state_t         state_d;
  logic [SCORE_W-1:0] frame_cnt;
  logic [AW:0]        fifo_count;
  logic [AW:0]        fifo_free;
  logic [FW-1:0]      free_eff;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] rd_data;
  logic               wr_en;
  logic               rd_en;
  logic               corner_req;
  logic               frame_end;
  logic               corner_acc;
  logic               corner_drop;
  logic               eof_wr;

  assign m_valid    = (fifo_count != '0);
  assign rd_en      = m_valid && m_ready;
  // Room is judged after this cycle's read so a full FIFO can still accept.
  assign free_eff   = {1'b0, fifo_free} + {{(AW+1){1'b0}}, rd_en};
  assign corner_req = ce && iscorner;
  assign frame_end  = ce && (x_coord == LAST_X) && (y_coord == LAST_Y);

  assign m_eof   = rd_data[EOF_BIT];
  assign m_x     = rd_data[X_LSB +: COORD_W];
  assign m_y     = rd_data[Y_LSB +: COORD_W];
  assign m_score = rd_data[S_LSB +: SCORE_W];

  fast_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (fifo_count),
    .free    (fifo_free)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_RUN;
    else      state_q <= state_d;
  end

  // Corners keep one slot in reserve so the frame marker always fits.
  always_comb begin
    state_d     = state_q;
    wr_en       = 1'b0;
    wr_data     = '0;
    corner_acc  = 1'b0;
    corner_drop = 1'b0;
    eof_wr      = 1'b0;
    case (state_q)
      S_RUN: begin
        if (corner_req) begin
          if (free_eff >= FW'(2) && frame_cnt < CORNER_CAP) begin
            wr_en      = 1'b1;
            wr_data    = pack_entry(1'b0, x_coord, y_coord, score);
            corner_acc = 1'b1;
          end else begin
            corner_drop = 1'b1;
          end
        end
        if (frame_end) state_d = S_EOF;
      end
      S_EOF: begin
        corner_drop = corner_req;
        if (free_eff >= FW'(1)) begin
          wr_en   = 1'b1;
          wr_data = pack_entry(1'b1, '0, '0, frame_cnt);
          eof_wr  = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (eof_wr)          frame_cnt <= '0;
      else if (corner_acc) frame_cnt <= frame_cnt + SCORE_W'(1);
      if (corner_drop)     overflow  <= 1'b1;
    end
  end

`ifdef FAST_CORNER_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 drop_cnt <= '0;
    else if (corner_drop && drop_cnt != '1)   drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fast_corner_fifo.sv
// Randomized self-checking bench for fast_corner_fifo on a tiny 8x4 frame, depth-8 FIFO.
module tb_fast_corner_fifo;

  localparam int COLS  = 8;
  localparam int ROWS  = 4;
  localparam int DEPTH = 8;
  localparam int CAP   = 12;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        iscorner;
  logic [9:0]  x_coord;
  logic [9:0]  y_coord;
  logic [12:0] score;
  logic        m_valid;
  logic        m_ready;
  logic        m_eof;
  logic [9:0]  m_x;
  logic [9:0]  m_y;
  logic [12:0] m_score;
  logic        overflow;
`ifdef FAST_CORNER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  fast_corner_fifo #(
    .COL_NUM     (COLS),
    .ROW_NUM     (ROWS),
    .FIFO_DEPTH  (DEPTH),
    .MAX_CORNERS (CAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .iscorner (iscorner),
    .x_coord  (x_coord),
    .y_coord  (y_coord),
    .score    (score),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_eof    (m_eof),
    .m_x      (m_x),
    .m_y      (m_y),
    .m_score  (m_score),
    .overflow (overflow)
`ifdef FAST_CORNER_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: queue of buffered entries plus per-frame bookkeeping.
  logic [33:0] model_q[$];
  logic [33:0] seen_q[$];
  bit          pend_eof;
  int          frame_cnt_m;
  logic        ovf_m;
  int          drop_m;
  int          n_cmp;
  int          n_err;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    pend_eof    = 1'b0;
    frame_cnt_m = 0;
    ovf_m       = 1'b0;
    drop_m      = 0;
  endtask

  task automatic modelDrop();
    ovf_m = 1'b1;
    if (drop_m < 65535) drop_m++;
  endtask

  task automatic modelStep(input logic c, input logic i, input logic [9:0] x,
                           input logic [9:0] y, input logic [12:0] s, input logic r);
    int free;
    if (r && model_q.size() != 0) void'(model_q.pop_front());
    free = DEPTH - model_q.size();
    if (!pend_eof) begin
      if (c && i) begin
        if (free >= 2 && frame_cnt_m < CAP) begin
          model_q.push_back({1'b0, x, y, s});
          frame_cnt_m++;
        end else begin
          modelDrop();
        end
      end
      if (c && x == 10'(COLS - 1) && y == 10'(ROWS - 1)) pend_eof = 1'b1;
    end else begin
      if (c && i) modelDrop();
      if (free >= 1) begin
        model_q.push_back({1'b1, 10'd0, 10'd0, 13'(frame_cnt_m)});
        frame_cnt_m = 0;
        pend_eof    = 1'b0;
      end
    end
  endtask

  task automatic compareState();
    checkOutput("m_valid", m_valid, model_q.size() != 0);
    if (model_q.size() != 0) checkOutput("m_entry", {m_eof, m_x, m_y, m_score}, model_q[0]);
    checkOutput("overflow", overflow, ovf_m);
`ifdef FAST_CORNER_DROP_CNT_EN
    checkOutput("drop_cnt", drop_cnt, 16'(drop_m));
`endif
  endtask

  // Drive one cycle away from the edge, then compare just after the edge.
  task automatic applyStimulus(input logic c, input logic i, input logic [9:0] x,
                               input logic [9:0] y, input logic [12:0] s, input logic r);
    ce = c; iscorner = i; x_coord = x; y_coord = y; score = s; m_ready = r;
    if (m_valid && r) seen_q.push_back({m_eof, m_x, m_y, m_score});
    modelStep(c, i, x, y, s, r);
    @(posedge clk);
    #1;
    compareState();
  endtask

  task automatic idleCycles(input int n, input logic r);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 10'd0, 10'd0, 13'd0, r);
  endtask

  task automatic runFrame(input logic [31:0] mask, input logic r);
    for (int p = 0; p < COLS * ROWS; p++)
      applyStimulus(1'b1, mask[p], 10'(p % COLS), 10'(p / COLS), 13'(p * 7 + 1), r);
  endtask

  task automatic runRandomFrame();
    int rdy_pct;
    rdy_pct = ($urandom_range(0, 2) == 0) ? 20 : (($urandom_range(0, 1) == 0) ? 60 : 95);
    for (int p = 0; p < COLS * ROWS; p++) begin
      while ($urandom_range(0, 4) == 0)
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 10'($urandom), 10'($urandom),
                      13'($urandom), 1'($urandom_range(0, 99) < rdy_pct));
      applyStimulus(1'b1, 1'($urandom_range(0, 9) < 4), 10'(p % COLS), 10'(p / COLS),
                    13'($urandom), 1'($urandom_range(0, 99) < rdy_pct));
    end
  endtask

  function automatic logic [33:0] seenAt(input int idx);
    if (idx >= 0 && idx < seen_q.size()) return seen_q[idx];
    return '1;
  endfunction

  int base;

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b0; ce = 1'b0; iscorner = 1'b0; x_coord = '0; y_coord = '0; score = '0; m_ready = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", m_valid, 1'b0);
    checkOutput("rst_data", {m_eof, m_x, m_y, m_score}, 34'd0);
    checkOutput("rst_ovf", overflow, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Two tiny frames, consumer always ready
    base = seen_q.size();
    runFrame(32'h0020_0400, 1'b1);
    idleCycles(4, 1'b1);
    checkOutput("t2_len", seen_q.size() - base, 3);
    checkOutput("t2_c0", seenAt(base), {1'b0, 10'd2, 10'd1, 13'd71});
    checkOutput("t2_c1", seenAt(base + 1), {1'b0, 10'd5, 10'd2, 13'd148});
    checkOutput("t2_eof", seenAt(base + 2), {1'b1, 10'd0, 10'd0, 13'd2});
    base = seen_q.size();
    runFrame(32'h0000_0221, 1'b1);
    idleCycles(4, 1'b1);
    checkOutput("t2b_len", seen_q.size() - base, 4);
    checkOutput("t2b_eof", seenAt(base + 3), {1'b1, 10'd0, 10'd0, 13'd3});

    // Corner on the very last pixel precedes the marker
    base = seen_q.size();
    runFrame(32'h8000_0001, 1'b1);
    idleCycles(4, 1'b1);
    checkOutput("t3_len", seen_q.size() - base, 3);
    checkOutput("t3_last", seenAt(base + 1), {1'b0, 10'd7, 10'd3, 13'd218});
    checkOutput("t3_eof", seenAt(base + 2), {1'b1, 10'd0, 10'd0, 13'd2});

    // Backpressure: 10 corners into depth 8, reserved slot for the marker
    base = seen_q.size();
    runFrame(32'h0000_03FF, 1'b0);
    idleCycles(1, 1'b0);
    checkOutput("t4_ovf", overflow, 1'b1);
`ifdef FAST_CORNER_DROP_CNT_EN
    checkOutput("t4_drops", drop_cnt, 16'd3);
`endif
    idleCycles(12, 1'b1);
    checkOutput("t4_len", seen_q.size() - base, 8);
    checkOutput("t4_c6", seenAt(base + 6), {1'b0, 10'd6, 10'd0, 13'd43});
    checkOutput("t4_eof", seenAt(base + 7), {1'b1, 10'd0, 10'd0, 13'd7});

    // Asynchronous reset with five entries buffered
    for (int p = 0; p < 5; p++)
      applyStimulus(1'b1, 1'b1, 10'(p), 10'd0, 13'(p + 100), 1'b0);
    checkOutput("t1_pre", m_valid, 1'b1);
    #2;
    rst = 1'b0;
    ce  = 1'b0;
    #1;
    checkOutput("t1_valid", m_valid, 1'b0);
    checkOutput("t1_ovf", overflow, 1'b0);
    checkOutput("t1_data", {m_eof, m_x, m_y, m_score}, 34'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 10'd10, 10'd20, 13'd300, 1'b0);
    checkOutput("t1_lat", {m_valid, m_eof, m_x, m_y, m_score}, {1'b1, 1'b0, 10'd10, 10'd20, 13'd300});
    runFrame(32'h0, 1'b1);
    idleCycles(4, 1'b1);
    checkOutput("t1_c", seenAt(seen_q.size() - 2), {1'b0, 10'd10, 10'd20, 13'd300});
    checkOutput("t1_eof", seenAt(seen_q.size() - 1), {1'b1, 10'd0, 10'd0, 13'd1});

    // Per-frame cap
    base = seen_q.size();
    runFrame(32'h0000_3FFF, 1'b1);
    idleCycles(4, 1'b1);
    checkOutput("t5_len", seen_q.size() - base, 13);
    checkOutput("t5_c11", seenAt(base + 11), {1'b0, 10'd3, 10'd1, 13'd78});
    checkOutput("t5_eof", seenAt(base + 12), {1'b1, 10'd0, 10'd0, 13'd12});
    checkOutput("t5_ovf", overflow, 1'b1);

    // Random frames with random backpressure
    for (int f = 0; f < 1000; f++) runRandomFrame();
    idleCycles(30, 1'b1);
    checkOutput("final_empty", m_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
